// File: rtl/start_seq_pkg.sv
// Shared definitions for the start-signal sequencer: FSM state encoding,
// register word addresses and STATUS / CTRL bit positions.
package start_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_TMO    = 2'd3;

  localparam int CTRL_GO      = 0;
  localparam int CTRL_MASK_LO = 1;
  localparam int CTRL_MASK_HI = 2;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE_LO  = 1;
  localparam int STAT_DONE_HI  = 2;
  localparam int STAT_TIMEOUT  = 3;
  localparam int STAT_IRQ_PEND = 4;

endpackage

// File: rtl/start_seq_timer.sv
// Loadable down-counter shared by the pulse-width and timeout phases.
// expired is high while the current cycle is the last one of the loaded
// span (count of 1), and also for a loaded value of 0.
module start_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  // Load takes priority over counting; the counter parks at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/start_signal_sequencer.sv
// Avalon-MM controlled start sequencer: a GO write launches a start pulse on
// the selected channels, then waits for their done indications and raises
// a level interrupt.
// Optional feature: define START_SEQ_TIMEOUT_EN to add the TMO register and
// a WAIT-phase timeout; without it TMO reads 0 and WAIT lasts indefinitely.
module start_signal_sequencer #(
  parameter int PULSE_W_BITS = 8,
  parameter int TMO_BITS     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  start_out,
  input  logic [1:0]  done_in,
  output logic        irq
);

  import start_seq_pkg::*;

  localparam int CNT_W = (PULSE_W_BITS > TMO_BITS) ? PULSE_W_BITS : TMO_BITS;

  state_t                  state, state_nxt;
  logic [1:0]              ch_mask, run_mask;
  logic [PULSE_W_BITS-1:0] pulse_len;
  logic [1:0]              done_flags, done_upd;
  logic                    timeout_flag, irq_pend, busy, all_done;
  logic                    wr_en, go_req, irq_clr;
  logic                    go_accept, finish_hit, timeout_hit;
  logic                    tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0]        tmr_load_val;
  logic                    unused_wdata;
`ifdef START_SEQ_TIMEOUT_EN
  logic [TMO_BITS-1:0]     tmo_limit, run_tmo;
`endif

  assign wr_en   = chipselect & ~write_n;
  assign go_req  = wr_en && (address == ADDR_CTRL) && writedata[CTRL_GO] &&
                   (writedata[CTRL_MASK_HI:CTRL_MASK_LO] != 2'b00);
  assign irq_clr = wr_en && (address == ADDR_STATUS) && writedata[STAT_IRQ_PEND];
  assign busy    = (state != ST_IDLE);

  // The done_in sample of the current cycle counts toward completion, so a
  // done arriving in the last timeout cycle still wins over the timeout.
  assign done_upd     = done_flags | (done_in & run_mask);
  assign all_done     = ((done_upd & run_mask) == run_mask);
  assign unused_wdata = ^writedata;

  start_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .enable   (tmr_en),
    .expired  (tmr_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state, timer control and event strobes.
  always_comb begin
    state_nxt    = state;
    go_accept    = 1'b0;
    finish_hit   = 1'b0;
    timeout_hit  = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go_req) begin
          go_accept    = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = (pulse_len == '0) ? CNT_W'(1) : CNT_W'(pulse_len);
          state_nxt    = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmr_expired) begin
          tmr_load  = 1'b1;
`ifdef START_SEQ_TIMEOUT_EN
          tmr_load_val = CNT_W'(run_tmo);
`endif
          state_nxt = ST_WAIT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        if (all_done) begin
          finish_hit = 1'b1;
          state_nxt  = ST_FINISH;
        end
`ifdef START_SEQ_TIMEOUT_EN
        else if (tmr_expired) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
`endif
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Host-visible configuration; new values only matter at the next GO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_mask   <= 2'b00;
      pulse_len <= PULSE_W_BITS'(1);
`ifdef START_SEQ_TIMEOUT_EN
      tmo_limit <= '1;
`endif
    end else if (wr_en) begin
      case (address)
        ADDR_CTRL:  ch_mask   <= writedata[CTRL_MASK_HI:CTRL_MASK_LO];
        ADDR_PULSE: pulse_len <= writedata[PULSE_W_BITS-1:0];
`ifdef START_SEQ_TIMEOUT_EN
        ADDR_TMO:   tmo_limit <= writedata[TMO_BITS-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Per-sequence snapshot taken when GO is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_mask <= 2'b00;
`ifdef START_SEQ_TIMEOUT_EN
      run_tmo  <= '0;
`endif
    end else if (go_accept) begin
      run_mask <= writedata[CTRL_MASK_HI:CTRL_MASK_LO];
`ifdef START_SEQ_TIMEOUT_EN
      run_tmo  <= tmo_limit;
`endif
    end
  end

  // Sticky status flags; an IRQ set beats a simultaneous host clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_flags   <= 2'b00;
      timeout_flag <= 1'b0;
      irq_pend     <= 1'b0;
    end else begin
      if (go_accept)                                   done_flags <= 2'b00;
      else if (state == ST_PULSE || state == ST_WAIT) done_flags <= done_upd;
      if (go_accept)        timeout_flag <= 1'b0;
      else if (timeout_hit) timeout_flag <= 1'b1;
      if (finish_hit || timeout_hit) irq_pend <= 1'b1;
      else if (irq_clr)              irq_pend <= 1'b0;
    end
  end

  // Zero-wait-state register read mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:  readdata[CTRL_MASK_HI:CTRL_MASK_LO] = ch_mask;
      ADDR_PULSE: readdata = 32'(pulse_len);
      ADDR_STATUS: begin
        readdata[STAT_BUSY]                  = busy;
        readdata[STAT_DONE_HI:STAT_DONE_LO]  = done_flags;
        readdata[STAT_TIMEOUT]               = timeout_flag;
        readdata[STAT_IRQ_PEND]              = irq_pend;
      end
`ifdef START_SEQ_TIMEOUT_EN
      ADDR_TMO:   readdata = 32'(tmo_limit);
`else
      ADDR_TMO:   readdata = '0;
`endif
    endcase
  end

  assign start_out = (state == ST_PULSE) ? run_mask : 2'b00;
  assign irq       = irq_pend;

endmodule

// File: doc/start_signal_sequencer.md
START_SIGNAL_SEQUENCER -- requirements
Module: start_signal_sequencer

Interface
REQ-001 SHALL have parameter PULSE_W_BITS, default 8, width of the pulse-length register.
REQ-002 SHALL have parameter TMO_BITS, default 16, width of the timeout-limit register.
REQ-003 SHALL have port clk  in  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port address  in  2  Avalon-MM word address.
REQ-006 SHALL have port chipselect  in  1  slave select.
REQ-007 SHALL have port write_n  in  1  active-low write strobe.
REQ-008 SHALL have port writedata  in  32  write data.
REQ-009 SHALL have port readdata  out  32  combinational read data, zero wait states.
REQ-010 SHALL have port start_out  out  2  per-channel start level to the datapath engines.
REQ-011 SHALL have port done_in  in  2  per-channel completion pulses or levels, synchronous to clk.
REQ-012 SHALL have port irq  out  1  level interrupt, high while IRQ_PEND=1.

Function
REQ-013 SHALL decode registers as follows: 0 CTRL (wr bit0 GO, self-clearing; bits[2:1] CH_MASK); 1 PULSE (pulse width in cycles); 2 STATUS; 3 TMO (timeout limit).
REQ-014 SHALL read back: CTRL = {29'b0, CH_MASK, 1'b0}; PULSE and TMO zero-extended; STATUS = {27'b0, IRQ_PEND, TIMEOUT, DONE[1:0], BUSY}.
REQ-015 SHALL implement FSM states IDLE, PULSE, WAIT, FINISH.
REQ-016 SHALL, in IDLE on a GO write with CH_MASK≠0 in the written data, snapshot the mask and width, clear DONE and TIMEOUT, and enter PULSE.
REQ-017 SHALL ignore GO when the written mask is 0 or when BUSY=1, leaving state unchanged.
REQ-018 SHALL drive start_out = snapshot mask in PULSE, starting the cycle after the GO write, for exactly max(PULSE,1) cycles, then enter WAIT.
REQ-019 SHALL drive start_out=0 in IDLE, WAIT, and FINISH.
REQ-020 SHALL OR done_in & mask into sticky DONE[1:0] in both PULSE and WAIT.
REQ-021 SHALL go from WAIT to FINISH when DONE covers the mask; FINISH SHALL set IRQ_PEND for 1 cycle, then return to IDLE.
REQ-022 SHALL assert BUSY=1 in PULSE, WAIT, and FINISH.
REQ-023 SHALL accept PULSE, TMO, and CTRL mask writes at any time; the new values take effect at the next GO.
REQ-024 SHALL clear IRQ_PEND on a write of 1 to STATUS bit4; if a set and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force: state IDLE, start_out 0, irq 0, CH_MASK 0, PULSE 1, TMO all-ones, DONE 0, TIMEOUT 0, IRQ_PEND 0.
REQ-026 SHALL drop start_out immediately when reset is asserted mid-sequence, and SHALL leave no pending completion after release.

Configuration
REQ-027 SHALL, with START_SEQ_TIMEOUT_EN defined, count WAIT cycles; on count==TMO, it SHALL set TIMEOUT and IRQ_PEND and return to IDLE.
REQ-028 SHALL give completion priority when completion and timeout occur in the same cycle: FINISH, TIMEOUT=0.
REQ-029 SHALL, without START_SEQ_TIMEOUT_EN, omit the TMO register (reads 0, writes ignored), hold TIMEOUT at 0, and let WAIT last indefinitely.

Structure
REQ-030 SHALL take the state enum, register address constants (ADDR_CTRL..ADDR_TMO), and STATUS bit indices from package start_seq_pkg.
REQ-031 SHALL isolate the pulse-width/timeout down-counter as sub-module start_seq_timer (load, enable, expired).

Verification
REQ-032 SHALL cover: PULSE=3, write CTRL=0x3 -> start_out=2'b11 for exactly 3 cycles beginning the next cycle; BUSY=1.
REQ-033 SHALL cover: mask 2'b01, done_in[0] pulse 5 cycles after GO -> FINISH, STATUS=0x13, irq=1; write STATUS=0x10 -> irq=0.
REQ-034 SHALL cover: GO with mask 0, and a second GO while BUSY -> no start_out change, state unchanged.
REQ-035 SHALL cover, with START_SEQ_TIMEOUT_EN: TMO=10, no done -> TIMEOUT=1, irq=1 after 10 WAIT cycles; done and expiry in the same cycle -> TIMEOUT=0.
REQ-036 SHALL cover: reset_n low during PULSE -> start_out=0 asynchronously; after release, all registers hold reset values.
REQ-037 SHALL cover: PULSE=0 -> 1-cycle start pulse; a PULSE write mid-WAIT does not alter the current sequence.
